// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state type for the memory access stage
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_R
    } mem_state_t;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select and sign/zero extension
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    // Move the addressed byte/half down to bit 0.
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // Extend the selected lane; unknown width codes fall back to a full word.
    always_comb begin
        o_data = i_rdata;
        case (i_func3)
            F3_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_data = {24'h000000, w_shifted[7:0]};
            F3_LHU:  o_data = {16'h0000, w_shifted[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: data-memory handshake, stall, M/W register
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_index,
    input  logic [3:0]      dm_w_en,
    input  logic            wb_sel,
    input  logic            wb_en,
    input  logic [2:0]      func3,
    input  logic            ecall_sig,
    output logic            dm_req,
    output logic [3:0]      dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            mem_stall,
    output logic [XLEN-1:0] wb_data_reg,
    output logic [4:0]      rd_index_reg,
    output logic            wb_en_reg,
    output logic            ecall_reg,
    output logic            misalign_err,
    output logic            bus_err
);

    localparam int            TW        = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);

    mem_state_t  r_state;
    logic [TW-1:0] r_tcnt;

    logic        w_load;
    logic        w_store;
    logic        w_memop;
    logic        w_half;
    logic        w_word;
    logic        w_misalign;
    logic        w_issue;
    logic        w_stall_cand;
    logic        w_timeout;
    logic [31:0] w_load_data;

    assign w_load     = wb_sel & wb_en;
    assign w_store    = (dm_w_en != 4'b0000);
    assign w_memop    = w_load | w_store;
    assign w_half     = (dm_w_en == MASK_H) || (func3[1:0] == 2'b01);
    assign w_word     = (dm_w_en == MASK_W) || (func3[1:0] == 2'b10);
    assign w_misalign = (r_state == ST_IDLE) && w_memop &&
                        ((w_half && alu_out[0]) || (w_word && (alu_out[1:0] != 2'b00)));
    assign w_issue    = (r_state == ST_IDLE) && w_memop && !w_misalign;

    // A cycle would stall if the request is not yet granted, a granted load still
    // needs its data, or the read data has not arrived yet.
    assign w_stall_cand = (w_issue && (!dm_gnt || w_load)) ||
                          ((r_state == ST_WAIT_R) && !dm_rvalid);
    assign w_timeout    = (TIMEOUT_CYC != 0) && w_stall_cand && (r_tcnt == TCNT_LAST);

    assign mem_stall = rst && w_stall_cand && !w_timeout;
    assign dm_req    = rst && w_issue;
    assign dm_we     = w_issue ? 4'(dm_w_en << alu_out[1:0]) : 4'b0000;
    assign dm_addr   = {alu_out[XLEN-1:2], 2'b00};
    assign dm_wdata  = rs2_data << {alu_out[1:0], 3'b000};

    mem_load_align u_align (
        .i_rdata   (dm_rdata),
        .i_addr_lo (alu_out[1:0]),
        .i_func3   (func3),
        .o_data    (w_load_data)
    );

    // Access FSM, timeout counter and the memory-to-writeback register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_tcnt       <= '0;
            wb_data_reg  <= '0;
            rd_index_reg <= '0;
            wb_en_reg    <= 1'b0;
            ecall_reg    <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else if (mem_stall) begin
            // Bubble into WB while the access is outstanding.
            wb_en_reg    <= 1'b0;
            ecall_reg    <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            r_tcnt       <= r_tcnt + TW'(1);
            if (r_state == ST_IDLE && dm_gnt) begin
                r_state <= ST_WAIT_R;
            end
        end else begin
            r_state      <= ST_IDLE;
            r_tcnt       <= '0;
            rd_index_reg <= rd_index;
            misalign_err <= w_misalign;
            bus_err      <= w_timeout;
            if (w_timeout) begin
                wb_data_reg <= alu_out;
                wb_en_reg   <= 1'b0;
                ecall_reg   <= 1'b0;
            end else if (r_state == ST_WAIT_R) begin
                wb_data_reg <= w_load_data;
                wb_en_reg   <= 1'b1;
                ecall_reg   <= ecall_sig;
            end else if (w_misalign || w_store) begin
                wb_data_reg <= alu_out;
                wb_en_reg   <= 1'b0;
                ecall_reg   <= ecall_sig;
            end else begin
                wb_data_reg <= alu_out;
                wb_en_reg   <= wb_en;
                ecall_reg   <= ecall_sig;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out, rs2_data, dm_rdata;
    logic [4:0]  rd_index;
    logic [3:0]  dm_w_en;
    logic        wb_sel, wb_en, ecall_sig, dm_gnt, dm_rvalid;
    logic [2:0]  func3;
    logic        dm_req, mem_stall, wb_en_reg, ecall_reg, misalign_err, bus_err;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr, dm_wdata, wb_data_reg;
    logic [4:0]  rd_index_reg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .alu_out(alu_out), .rs2_data(rs2_data),
        .rd_index(rd_index), .dm_w_en(dm_w_en), .wb_sel(wb_sel), .wb_en(wb_en),
        .func3(func3), .ecall_sig(ecall_sig), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
        .wb_data_reg(wb_data_reg), .rd_index_reg(rd_index_reg),
        .wb_en_reg(wb_en_reg), .ecall_reg(ecall_reg),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input logic [2:0] f3);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (8 * off)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b - 256   : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic drive_nop();
        alu_out = 0; rs2_data = 0; rd_index = 0; dm_w_en = 0;
        wb_sel = 0; wb_en = 0; func3 = 0; ecall_sig = 0;
        dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
    endtask

    // One instruction through the stage; gd = cycles before grant, rl = grant-to-rvalid.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d2,
                          input logic [4:0] rdi, input logic [3:0] we, input logic sel,
                          input logic en, input logic [2:0] f3, input logic ec,
                          input int gd, input int rl, input logic [31:0] rdw);
        bit ld, st, mop, mis, half, word, tmo, done;
        int off, cand, exp_stalls, stalls;
        ld   = sel && en;
        st   = (we != 0);
        mop  = ld || st;
        off  = a % 4;
        half = (we == 4'd3) || (f3[1:0] == 2'd1);
        word = (we == 4'd15) || (f3[1:0] == 2'd2);
        mis  = mop && ((half && (off % 2 == 1)) || (word && off != 0));
        if (!mop || mis) cand = 0;
        else if (ld)     cand = gd + rl;
        else             cand = gd;
        tmo        = (cand >= T);
        exp_stalls = tmo ? T - 1 : cand;

        alu_out = a; rs2_data = d2; rd_index = rdi; dm_w_en = we;
        wb_sel = sel; wb_en = en; func3 = f3; ecall_sig = ec;
        stalls = 0; done = 0;
        for (int c = 0; c < 12 && !done; c++) begin
            dm_gnt    = (c == gd);
            dm_rvalid = ld && (c == gd + rl);
            dm_rdata  = (c == gd + rl) ? rdw : $urandom;
            @(negedge clk);
            if (c == 0) begin
                chk({tag, "_req"}, dm_req, mop && !mis);
                if (mop && !mis) begin
                    chk({tag, "_we"},    dm_we,    (we * (1 << off)) & 4'hF);
                    chk({tag, "_addr"},  dm_addr,  a - off);
                    chk({tag, "_wdata"}, dm_wdata, d2 * (1 << (8 * off)));
                end
            end else begin
                chk({tag, "_bubble"}, wb_en_reg, 0);
                if (ld && c > gd) chk({tag, "_req_wait"}, dm_req, 0);
            end
            if (mem_stall) stalls++;
            else           done = 1;
            @(posedge clk);
            #1;
        end
        dm_gnt = 0; dm_rvalid = 0;
        chk({tag, "_bound"}, done, 1);
        chk({tag, "_stalls"}, stalls, exp_stalls);
        chk({tag, "_misalign"}, misalign_err, mis);
        chk({tag, "_bus_err"}, bus_err, mop && !mis && tmo);
        if (!mop) begin
            chk({tag, "_wb_en"}, wb_en_reg, en);
            chk({tag, "_wb_data"}, wb_data_reg, a);
        end else begin
            chk({tag, "_wb_en"}, wb_en_reg, ld && !mis && !tmo);
            if (ld && !mis && !tmo) chk({tag, "_wb_data"}, wb_data_reg, model_load(rdw, off, f3));
        end
        if (!mis && !tmo) begin
            chk({tag, "_rd"}, rd_index_reg, rdi);
            chk({tag, "_ecall"}, ecall_reg, ec);
        end
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        int kind, sz;
        logic [2:0] f3r;
        ld_f3[0] = F3_LB; ld_f3[1] = F3_LH; ld_f3[2] = F3_LW;
        ld_f3[3] = F3_LBU; ld_f3[4] = F3_LHU;

        drive_nop();
        rst = 1'b0;
        #1;
        chk("rst_req", dm_req, 0);
        chk("rst_wb_en", wb_en_reg, 0);
        chk("rst_wb_data", wb_data_reg, 0);
        chk("rst_bus_err", bus_err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_op("pass", 32'h1234, 0, 5'd5, 4'b0000, 0, 1, 3'd0, 0, 0, 1, 0);
        run_op("sb", 32'h103, 32'hAB, 5'd3, MASK_B, 0, 0, F3_LB, 0, 2, 1, 0);
        run_op("lb", 32'h101, 0, 5'd9, 4'b0000, 1, 1, F3_LB, 0, 0, 1, 32'h0000_8000);
        run_op("lbu", 32'h101, 0, 5'd9, 4'b0000, 1, 1, F3_LBU, 1, 0, 1, 32'h0000_8000);
        run_op("sw_mis", 32'h102, 32'h55, 5'd4, MASK_W, 0, 0, F3_LW, 0, 0, 1, 0);
        run_op("lw_tmo", 32'h200, 0, 5'd6, 4'b0000, 1, 1, F3_LW, 0, 0, 10, 32'h1111_2222);
        run_op("lh_hi", 32'h302, 0, 5'd8, 4'b0000, 1, 1, F3_LH, 0, 1, 1, 32'h9ABC_0000);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                run_op("rnd_pass", $urandom, $urandom, 5'($urandom), 4'b0000,
                       1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 0, 1, 0);
            end else if (kind == 1) begin
                sz  = $urandom_range(0, 2);
                f3r = 3'(sz);
                run_op("rnd_st", $urandom, $urandom, 5'($urandom),
                       (sz == 0) ? MASK_B : (sz == 1) ? MASK_H : MASK_W,
                       0, 0, f3r, 1'($urandom), $urandom_range(0, 4), 1, 0);
            end else begin
                run_op("rnd_ld", $urandom, 0, 5'($urandom), 4'b0000, 1, 1,
                       ld_f3[$urandom_range(0, 4)], 1'($urandom),
                       $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
            end
        end

        run_op("pre_rst", 32'hDEAD_BEEF, 0, 5'd7, 4'b0000, 0, 1, 3'd0, 1, 0, 1, 0);
        alu_out = 32'h400; rd_index = 5'd2; dm_w_en = 0; wb_sel = 1; wb_en = 1;
        func3 = F3_LW; ecall_sig = 0; dm_gnt = 1; dm_rvalid = 0;
        @(negedge clk);
        chk("wr_stall", mem_stall, 1);
        @(posedge clk);
        #1;
        dm_gnt = 0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", dm_req, 0);
        chk("arst_wb_data", wb_data_reg, 0);
        chk("arst_rd", rd_index_reg, 0);
        chk("arst_wb_en", wb_en_reg, 0);
        drive_nop();
        @(posedge clk);
        #1;
        rst = 1'b1;
        dm_rvalid = 1; dm_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        dm_rvalid = 0;
        chk("late_rvalid_wb_en", wb_en_reg, 0);
        chk("late_rvalid_data", wb_data_reg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory stage that consumes the registered execute-to-memory bundle: ALU result, rs2 data, rd index, byte write enables, wb_sel/wb_en, func3 and ecall.
It drives a handshaked data-memory port, stalls the upstream pipeline while an access is outstanding, and aligns/extends load data.
It registers the write-back bundle (the memory-to-writeback pipeline register) for the WB stage.

Parameters:
XLEN, 32, data/address width (only 32 is supported).
TIMEOUT_CYC, 255, maximum cycles an access may wait for dm_gnt/dm_rvalid; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
alu_out  in  32  effective address, or result for non-memory ops
rs2_data  in  32  store data, unshifted
rd_index  in  5  destination register
dm_w_en  in  4  unshifted store mask: 0001 SB, 0011 SH, 1111 SW, 0000 no store
wb_sel  in  1  1 = write-back from memory (load)
wb_en  in  1  register write enable
func3  in  3  load/store width and signedness
ecall_sig  in  1  ecall marker
dm_req  out  1  memory request valid
dm_we  out  4  lane-shifted byte enables (0000 = read)
dm_addr  out  32  word-aligned address, {alu_out[31:2],2'b00}
dm_wdata  out  32  rs2_data shifted left by 8*alu_out[1:0]
dm_gnt  in  1  request accepted this cycle
dm_rvalid  in  1  read data valid
dm_rdata  in  32  read word
mem_stall  out  1  freeze the execute-to-memory register and all earlier stages
wb_data_reg  out  32  write-back value
rd_index_reg  out  5  registered rd
wb_en_reg  out  1  registered write enable
ecall_reg  out  1  registered ecall (halt request)
misalign_err  out  1  one-cycle pulse on a misaligned access
bus_err  out  1  one-cycle pulse on a timeout

Behaviour:
- **Reset.** rst low forces the following immediately, regardless of clk:
  - all registered outputs and the timeout counter to 0;
  - state to IDLE;
  - dm_req is 0 while rst is low.
  - Reset during an outstanding access abandons it. A late dm_rvalid after reset is ignored.
- **Operation classes.**
  - load = wb_sel & wb_en.
  - store = (dm_w_en != 0).
  - Neither = pass-through op.
- **Misalignment.**
  - Misaligned if:
    - (halfword and alu_out[0]=1), where halfword = SH mask or func3[1:0]=01;
    - or (word and alu_out[1:0]!=0).
  - A misaligned access gets no dm_req and no stall. The M/W bundle is registered with wb_en_reg=0 and misalign_err=1 for one cycle.
- **FSM states:** IDLE, WAIT_R.
  - IDLE, load/store present and aligned:
    - dm_req=1 (combinational), with dm_we/dm_addr/dm_wdata valid.
    - These hold stable until dm_gnt.
  - IDLE, store with dm_gnt=1:
    - completes this cycle, mem_stall=0;
    - registers wb_en_reg=0.
  - IDLE, load with dm_gnt=1: next state WAIT_R, mem_stall=1.
  - IDLE, memory op with dm_gnt=0: mem_stall=1, stay in IDLE.
  - WAIT_R:
    - dm_req=0, mem_stall=1 until dm_rvalid.
    - On dm_rvalid: register formatted data, wb_en_reg=1, mem_stall=0 that cycle, return to IDLE.
    - dm_rvalid is never expected in the same cycle as dm_gnt.
  - Pass-through op: wb_data_reg<=alu_out, wb_en_reg<=wb_en, 1-cycle latency, no stall.
- **Bubble while stalled.** While mem_stall=1, wb_en_reg<=0 and ecall_reg<=0. No duplicate write-back.
- **Load formatting.** Select byte/half lane by alu_out[1:0], then extend per func3:
  - 000 sign-extend byte;
  - 001 sign-extend half;
  - 010 full word;
  - 100 zero-extend byte;
  - 101 zero-extend half;
  - other codes treated as 010.
- **Timeout counter.**
  - Clears in IDLE when not stalled. Increments each stalled cycle.
  - When it reaches TIMEOUT_CYC (nonzero):
    - bus_err pulses 1 cycle;
    - the access is dropped (state to IDLE, wb_en_reg=0, mem_stall=0 that cycle).
- **Ecall.** ecall_reg<=ecall_sig when the op completes or passes through.

Decomposition:
- Shared package mem_pkg holds:
  - func3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - store mask constants (MASK_B, MASK_H, MASK_W);
  - the state enum (ST_IDLE, ST_WAIT_R).
- One natural sub-module, mem_load_align: combinational lane select plus extension, with inputs rdata, addr[1:0], func3 and output 32-bit data.

Test Plan:
- Pass-through: alu_out=0x1234, wb_en=1, no mem op -> next cycle wb_data_reg=0x1234, wb_en_reg=1, mem_stall never 1.
- SB, alu_out=0x103, rs2_data=0xAB, dm_gnt after 2 cycles:
  - dm_we=1000, dm_addr=0x100, dm_wdata=0xAB000000;
  - mem_stall high 2 cycles;
  - wb_en_reg=0.
- LB at 0x101 with func3=000, dm_rdata=0x0000_8000, rvalid 1 cycle after gnt -> wb_data_reg=0xFFFFFF80, wb_en_reg=1. Same with func3=100 -> 0x00000080.
- SW at 0x102 -> no dm_req, misalign_err pulse, wb_en_reg=0, no stall.
- TIMEOUT_CYC=4, load granted but no rvalid -> bus_err pulses on the 4th stalled cycle, state IDLE, mem_stall drops.
- Drop rst in WAIT_R -> outputs 0 asynchronously. A later dm_rvalid produces no write-back.
